qsys_basic_sysid_checker: RTL

Boot-time Avalon-MM master. It reads the two words of the system-ID slave (ID at word 0, timestamp at word 1) and compares them against build-time expected values. It then reports pass/fail to the board-level status logic, which drives the LEDs or holds off the soft processor. It sits directly upstream of the system-ID slave's control port, either point-to-point or through the Qsys interconnect.

---
 rtl/qsys_basic_sysid_checker_if.sv | 22 ++
 rtl/qsys_basic_sysid_checker.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/qsys_basic_sysid_checker_if.sv
// Avalon-MM read-only bus between the sysid checker (master) and the
// system-ID slave control port.
interface qsys_basic_sysid_checker_if;
    logic        avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_readdata,
        input  avm_waitrequest
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_readdata,
        output avm_waitrequest
    );
endinterface

// File: rtl/qsys_basic_sysid_checker.sv
// Boot-time system-ID checker: reads ID (word 0) and timestamp (word 1) from
// the sysid slave, compares them with build-time values and reports the
// result to board-level status logic. All outputs are registered.
module qsys_basic_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'h1234ABCD,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h521ACFA3,
    parameter bit          CHECK_TIMESTAMP    = 1'b1,
    parameter bit          AUTO_START         = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES     = 1024
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               start,
    qsys_basic_sysid_checker_if.master         avm,
    output logic                               busy,
    output logic                               done,
    output logic                               pass,
    output logic                               id_mismatch,
    output logic                               ts_mismatch,
    output logic                               timeout,
    output logic [31:0]                        id_value,
    output logic [31:0]                        ts_value
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_ID = 2'd1,
        RD_TS = 2'd2,
        DONE  = 2'd3
    } state_t;

    // A zero limit disables the stall timeout entirely.
    localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic        auto_pending;
    logic        read_q;
    logic        addr_q;
    logic [15:0] stall_cnt;

    logic        launch;
    logic        stall_expired;
    logic        id_mm_now;
    logic        ts_mm_now;

    assign avm.avm_read    = read_q;
    assign avm.avm_address = addr_q;

    // Decode launch/compare conditions from current state and bus inputs.
    always_comb begin
        launch        = 1'b0;
        stall_expired = 1'b0;
        id_mm_now     = (avm.avm_readdata != EXPECTED_ID);
        ts_mm_now     = CHECK_TIMESTAMP && (avm.avm_readdata != EXPECTED_TIMESTAMP);
        if (state == IDLE) begin
            launch = start || auto_pending;
        end else if (state == DONE) begin
            launch = start;
        end
        if (TO_EN && avm.avm_waitrequest && (stall_cnt == TO_LAST)) begin
            stall_expired = 1'b1;
        end
    end

    // Single state machine with registered bus strobes and status outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            auto_pending <= AUTO_START;
            read_q       <= 1'b0;
            addr_q       <= 1'b0;
            stall_cnt    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            id_mismatch  <= 1'b0;
            ts_mismatch  <= 1'b0;
            timeout      <= 1'b0;
            id_value     <= '0;
            ts_value     <= '0;
        end else begin
            // Auto-start only applies to the first edge after reset release.
            auto_pending <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (launch) begin
                        state       <= RD_ID;
                        read_q      <= 1'b1;
                        addr_q      <= 1'b0;
                        busy        <= 1'b1;
                        stall_cnt   <= '0;
                        done        <= 1'b0;
                        pass        <= 1'b0;
                        id_mismatch <= 1'b0;
                        ts_mismatch <= 1'b0;
                        timeout     <= 1'b0;
                    end
                end
                RD_ID: begin
                    if (!avm.avm_waitrequest) begin
                        state       <= RD_TS;
                        addr_q      <= 1'b1;
                        stall_cnt   <= '0;
                        id_value    <= avm.avm_readdata;
                        id_mismatch <= id_mm_now;
                    end else if (stall_expired) begin
                        state     <= DONE;
                        read_q    <= 1'b0;
                        addr_q    <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        pass      <= 1'b0;
                        timeout   <= 1'b1;
                    end else begin
                        stall_cnt <= stall_cnt + 16'd1;
                    end
                end
                RD_TS: begin
                    // Completion is tested first so it wins a tie with the timeout.
                    if (!avm.avm_waitrequest) begin
                        state       <= DONE;
                        read_q      <= 1'b0;
                        addr_q      <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        ts_value    <= avm.avm_readdata;
                        ts_mismatch <= ts_mm_now;
                        pass        <= !id_mismatch && !ts_mm_now;
                    end else if (stall_expired) begin
                        state     <= DONE;
                        read_q    <= 1'b0;
                        addr_q    <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        pass      <= 1'b0;
                        timeout   <= 1'b1;
                    end else begin
                        stall_cnt <= stall_cnt + 16'd1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    read_q <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule
